vend_sequencer: RTL and testbench

Clocked controller that sequences one vending transaction: product select, price latch, coin acceptance, dispense and change return.
It drives the coin counter hold lines and the product release and stock-decrement strobes.
It takes the price from the price/discount datapath and per-product empty flags from the stock counters.
All money values are in units of 500: coin code 00=1, 01=2, 10=4, 11=10.

---
 rtl/vend_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_vend_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// Vending transaction sequencer: product select, price latch, coin acceptance,
// dispense and change return. Money values are in units of 500.
module vend_sequencer #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int MW          = 8
) (
    input  logic          clock,
    input  logic          CLR,
    input  logic [2:0]    Key,
    input  logic          KeyValid,
    input  logic [MW-1:0] PayPrice,
    input  logic [7:0]    ProdEmpty,
    input  logic [1:0]    InsertedMoney,
    input  logic          CoinValid,
    input  logic          Cancel,
    output logic [3:0]    HoldN,
    output logic          CoinReject,
    output logic          SelErr,
    output logic [7:0]    ReleasProd,
    output logic          DecStock,
    output logic          ChangeValid,
    output logic [1:0]    ChangeCoin,
    output logic [MW-1:0] TotalMoney,
    output logic          Busy,
    output logic [2:0]    State
);
    // Handshake: KeyValid and CoinValid are single-cycle strobes sampled on the
    // rising edge with no ready/backpressure; a strobe that arrives outside the
    // state that accepts it is dropped without any response.

    localparam logic [2:0] IDLE     = 3'b000;
    localparam logic [2:0] SELECT   = 3'b001;
    localparam logic [2:0] PAY      = 3'b010;
    localparam logic [2:0] DISPENSE = 3'b011;
    localparam logic [2:0] CHANGE   = 3'b100;

    localparam int            TW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    logic [2:0]    stateReg;
    logic [2:0]    stateNext;
    logic [2:0]    keyReg;
    logic [MW-1:0] priceReg;
    logic [MW-1:0] changeReg;
    logic [TW-1:0] timerReg;

    logic [MW-1:0] coinVal;
    logic [MW:0]   coinSum;
    logic          coinFits;
    logic          coinTaken;
    logic          paid;
    logic          timeoutHit;
    logic          abortPay;
    logic [MW-1:0] refundAmt;
    logic [1:0]    changeCode;
    logic [MW-1:0] changeAmt;

    // Shared datapath terms: coin value, overflow guard, refund and change coin.
    always_comb begin
        coinVal = MW'(1);
        case (InsertedMoney)
            2'b00:   coinVal = MW'(1);
            2'b01:   coinVal = MW'(2);
            2'b10:   coinVal = MW'(4);
            default: coinVal = MW'(10);
        endcase
        coinSum    = {1'b0, TotalMoney} + {1'b0, coinVal};
        coinFits   = !coinSum[MW];
        coinTaken  = (stateReg == PAY) && CoinValid && coinFits;
        paid       = TotalMoney >= priceReg;
        timeoutHit = !CoinValid && (timerReg >= TIMER_LAST);
        abortPay   = Cancel || timeoutHit;
        refundAmt  = coinTaken ? coinSum[MW-1:0] : TotalMoney;

        changeCode = 2'b00;
        changeAmt  = MW'(1);
        if (changeReg >= MW'(10)) begin
            changeCode = 2'b11;
            changeAmt  = MW'(10);
        end else if (changeReg >= MW'(4)) begin
            changeCode = 2'b10;
            changeAmt  = MW'(4);
        end else if (changeReg >= MW'(2)) begin
            changeCode = 2'b01;
            changeAmt  = MW'(2);
        end
    end

    always_ff @(posedge clock or posedge CLR) begin
        if (CLR) stateReg <= IDLE;
        else     stateReg <= stateNext;
    end

    always_comb begin
        stateNext = IDLE;
        case (stateReg)
            IDLE:     stateNext = (KeyValid && !ProdEmpty[Key]) ? SELECT : IDLE;
            SELECT:   stateNext = (PayPrice == '0) ? IDLE : PAY;
            PAY: begin
                // Being fully paid wins over a cancel or timeout in the same cycle.
                if (paid)          stateNext = DISPENSE;
                else if (abortPay) stateNext = (refundAmt != '0) ? CHANGE : IDLE;
                else               stateNext = PAY;
            end
            DISPENSE: stateNext = (TotalMoney != priceReg) ? CHANGE : IDLE;
            CHANGE:   stateNext = (changeReg <= changeAmt) ? IDLE : CHANGE;
            default:  stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge CLR) begin
        if (CLR) begin
            keyReg     <= '0;
            priceReg   <= '0;
            changeReg  <= '0;
            timerReg   <= '0;
            TotalMoney <= '0;
            HoldN      <= 4'b1111;
            CoinReject <= 1'b0;
            SelErr     <= 1'b0;
        end else begin
            HoldN      <= 4'b1111;
            CoinReject <= 1'b0;
            SelErr     <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (KeyValid) begin
                        if (ProdEmpty[Key]) SelErr <= 1'b1;
                        else                keyReg <= Key;
                    end
                end
                SELECT: begin
                    priceReg <= PayPrice;
                    if (PayPrice == '0) begin
                        SelErr <= 1'b1;
                    end else begin
                        TotalMoney <= '0;
                        timerReg   <= '0;
                    end
                end
                PAY: begin
                    if (CoinValid) begin
                        timerReg <= '0;
                        if (coinFits) begin
                            TotalMoney           <= coinSum[MW-1:0];
                            HoldN[InsertedMoney] <= 1'b0;
                        end else begin
                            CoinReject <= 1'b1;
                        end
                    end else if (timerReg < TIMER_LAST) begin
                        timerReg <= timerReg + TW'(1);
                    end
                    if (!paid && abortPay) changeReg <= refundAmt;
                end
                DISPENSE: begin
                    changeReg <= TotalMoney - priceReg;
                    if (TotalMoney == priceReg) TotalMoney <= '0;
                end
                CHANGE: begin
                    changeReg <= changeReg - changeAmt;
                    if (changeReg <= changeAmt) TotalMoney <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ReleasProd  = 8'h00;
        DecStock    = 1'b0;
        ChangeValid = 1'b0;
        ChangeCoin  = 2'b00;
        Busy        = (stateReg != IDLE);
        State       = stateReg;
        if (stateReg == DISPENSE) begin
            ReleasProd = 8'h01 << keyReg;
            DecStock   = 1'b1;
        end
        if (stateReg == CHANGE) begin
            ChangeValid = 1'b1;
            ChangeCoin  = changeCode;
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: scripted transactions with expected releases and
// change coins queued at stimulus time and consumed by an output monitor.
`timescale 1ns/1ps
module tb_vend_sequencer;
    localparam int MW   = 8;
    localparam int TOUT = 16;

    logic          clock = 1'b0;
    logic          CLR = 1'b1;
    logic [2:0]    Key = '0;
    logic          KeyValid = 1'b0;
    logic [MW-1:0] PayPrice = '0;
    logic [7:0]    ProdEmpty = '0;
    logic [1:0]    InsertedMoney = '0;
    logic          CoinValid = 1'b0;
    logic          Cancel = 1'b0;
    logic [3:0]    HoldN;
    logic          CoinReject;
    logic          SelErr;
    logic [7:0]    ReleasProd;
    logic          DecStock;
    logic          ChangeValid;
    logic [1:0]    ChangeCoin;
    logic [MW-1:0] TotalMoney;
    logic          Busy;
    logic [2:0]    State;

    int total = 0;
    int bad   = 0;
    int n;

    logic [7:0] relExpQ[$];
    logic [1:0] chgExpQ[$];

    always #5 clock = ~clock;

    vend_sequencer #(.TIMEOUT_CYC(TOUT), .MW(MW)) dut (
        .clock(clock), .CLR(CLR), .Key(Key), .KeyValid(KeyValid),
        .PayPrice(PayPrice), .ProdEmpty(ProdEmpty), .InsertedMoney(InsertedMoney),
        .CoinValid(CoinValid), .Cancel(Cancel), .HoldN(HoldN),
        .CoinReject(CoinReject), .SelErr(SelErr), .ReleasProd(ReleasProd),
        .DecStock(DecStock), .ChangeValid(ChangeValid), .ChangeCoin(ChangeCoin),
        .TotalMoney(TotalMoney), .Busy(Busy), .State(State)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pressKey(input logic [2:0] k, input logic [MW-1:0] price);
        Key = k;
        KeyValid = 1'b1;
        tick();
        KeyValid = 1'b0;
        PayPrice = price;
        tick();
        PayPrice = '0;
    endtask

    task automatic insertCoin(input logic [1:0] code);
        InsertedMoney = code;
        CoinValid = 1'b1;
        tick();
        CoinValid = 1'b0;
    endtask

    task automatic waitIdle(output int cnt);
        cnt = 0;
        while (Busy && cnt < 64) begin
            tick();
            cnt++;
        end
    endtask

    // Scoreboard: every release and change coin must match the queued expectation.
    always @(negedge clock) begin
        if (!CLR) begin
            if (ReleasProd != 8'h00 || DecStock) begin
                if (relExpQ.size() == 0)
                    checkVal("release_unexpected", 32'({DecStock, ReleasProd}), 32'h0);
                else
                    checkVal("release", 32'({DecStock, ReleasProd}), 32'({1'b1, relExpQ.pop_front()}));
            end
            if (ChangeValid) begin
                if (chgExpQ.size() == 0)
                    checkVal("change_unexpected", 32'(ChangeValid), 32'h0);
                else
                    checkVal("change_coin", 32'(ChangeCoin), 32'(chgExpQ.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        checkVal("rst_state", 32'(State), 32'h0);
        checkVal("rst_holdn", 32'(HoldN), 32'hF);
        checkVal("rst_outs", 32'({Busy, ChangeValid, SelErr, CoinReject, DecStock, ReleasProd}), 32'h0);
        checkVal("rst_total", 32'(TotalMoney), 32'h0);
        CLR = 1'b0;
        tick();

        // Key 6, price 6, coins 2 and 10 -> change 4 then 2
        pressKey(3'd6, 8'd6);
        checkVal("t1_pay_state", 32'(State), 32'h2);
        insertCoin(2'b01);
        checkVal("t1_total_a", 32'(TotalMoney), 32'd2);
        checkVal("t1_holdn_a", 32'(HoldN), 32'b1101);
        tick();
        checkVal("t1_holdn_idle", 32'(HoldN), 32'b1111);
        relExpQ.push_back(8'b0100_0000);
        chgExpQ.push_back(2'b10);
        chgExpQ.push_back(2'b01);
        insertCoin(2'b11);
        checkVal("t1_total_b", 32'(TotalMoney), 32'd12);
        checkVal("t1_holdn_b", 32'(HoldN), 32'b0111);
        tick();
        checkVal("t1_dispense", 32'(State), 32'h3);
        waitIdle(n);
        checkVal("t1_idle_lat", 32'(n), 32'd3);
        checkVal("t1_total_end", 32'(TotalMoney), 32'd0);

        // Key 2, price 4, exact payment
        relExpQ.push_back(8'b0000_0100);
        pressKey(3'd2, 8'd4);
        insertCoin(2'b10);
        checkVal("t2_total", 32'(TotalMoney), 32'd4);
        waitIdle(n);
        checkVal("t2_idle_lat", 32'(n), 32'd2);

        // Key 1, price 8, coin 2 then cancel -> refund 2
        pressKey(3'd1, 8'd8);
        insertCoin(2'b01);
        chgExpQ.push_back(2'b01);
        Cancel = 1'b1;
        tick();
        Cancel = 1'b0;
        checkVal("t3_change_state", 32'(State), 32'h4);
        tick();
        checkVal("t3_idle", 32'(State), 32'h0);
        checkVal("t3_total", 32'(TotalMoney), 32'd0);

        // Cancel with a coin in the same cycle: the coin is refunded too
        pressKey(3'd3, 8'd20);
        chgExpQ.push_back(2'b11);
        InsertedMoney = 2'b11;
        CoinValid = 1'b1;
        Cancel = 1'b1;
        tick();
        CoinValid = 1'b0;
        Cancel = 1'b0;
        checkVal("t3b_state", 32'(State), 32'h4);
        checkVal("t3b_total", 32'(TotalMoney), 32'd10);
        tick();
        checkVal("t3b_idle", 32'(State), 32'h0);

        // Timeout refund 16 cycles after the last coin
        pressKey(3'd0, 8'd3);
        insertCoin(2'b00);
        chgExpQ.push_back(2'b00);
        n = 0;
        while (!ChangeValid && n < 40) begin
            tick();
            n++;
        end
        checkVal("t4_timeout_lat", 32'(n), 32'd16);
        tick();
        checkVal("t4_idle", 32'(State), 32'h0);
        checkVal("t4_total", 32'(TotalMoney), 32'd0);

        // Overflow reject at 250, then exact 255
        pressKey(3'd4, 8'd255);
        for (int i = 0; i < 25; i++) insertCoin(2'b11);
        checkVal("t5_total_250", 32'(TotalMoney), 32'd250);
        insertCoin(2'b11);
        checkVal("t5_reject", 32'(CoinReject), 32'h1);
        checkVal("t5_total_kept", 32'(TotalMoney), 32'd250);
        checkVal("t5_holdn_kept", 32'(HoldN), 32'b1111);
        tick();
        checkVal("t5_reject_pulse", 32'(CoinReject), 32'h0);
        relExpQ.push_back(8'b0001_0000);
        insertCoin(2'b10);
        insertCoin(2'b00);
        checkVal("t5_total_255", 32'(TotalMoney), 32'd255);
        checkVal("t5_holdn_500", 32'(HoldN), 32'b1110);
        waitIdle(n);
        checkVal("t5_idle_lat", 32'(n), 32'd2);

        // Empty product and zero price are refused
        ProdEmpty = 8'b0010_0000;
        Key = 3'd5;
        KeyValid = 1'b1;
        tick();
        KeyValid = 1'b0;
        checkVal("t6_selerr", 32'(SelErr), 32'h1);
        checkVal("t6_state", 32'(State), 32'h0);
        tick();
        checkVal("t6_selerr_pulse", 32'(SelErr), 32'h0);
        ProdEmpty = 8'h00;
        pressKey(3'd3, 8'd0);
        checkVal("t6_zero_price", 32'({SelErr, State}), 32'({1'b1, 3'h0}));
        insertCoin(2'b11);
        checkVal("t6_idle_coin", 32'({CoinReject, HoldN, State}), 32'({1'b0, 4'b1111, 3'h0}));

        // Reset in the middle of a change sequence
        relExpQ.push_back(8'b1000_0000);
        chgExpQ.push_back(2'b10);
        pressKey(3'd7, 8'd1);
        insertCoin(2'b11);
        tick();
        tick();
        checkVal("t7_in_change", 32'({ChangeValid, State}), 32'({1'b1, 3'h4}));
        @(negedge clock);
        #1;
        CLR = 1'b1;
        #1;
        checkVal("t7_rst_state", 32'(State), 32'h0);
        checkVal("t7_rst_outs", 32'({Busy, ChangeValid, ReleasProd}), 32'h0);
        checkVal("t7_rst_holdn", 32'(HoldN), 32'hF);
        checkVal("t7_rst_total", 32'(TotalMoney), 32'h0);
        tick();
        tick();
        CLR = 1'b0;
        repeat (6) tick();
        checkVal("t7_after_state", 32'(State), 32'h0);

        checkVal("rel_q_left", 32'(relExpQ.size()), 32'h0);
        checkVal("chg_q_left", 32'(chgExpQ.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
